// File: rtl/reg_bank_pkg.sv
// Shared state encoding and helpers for the register-bank load arbiter.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Bit `pos` of the one-hot vector that encodes `idx`.
    function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
        return idx == pos;
    endfunction

endpackage

// File: rtl/reg_bank_load_arbiter_rr_pick.sv
// Rotating-priority selector: first set bit of req scanning upward from ptr, wrapping at NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   idx
);

    logic [PW:0] j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = {1'b0, ptr} + (PW+1)'(k);
            if (j >= (PW+1)'(NREQ)) begin
                j = j - (PW+1)'(NREQ);
            end
            if (!valid && req[j[PW-1:0]]) begin
                valid = 1'b1;
                idx   = j[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_bank_load_arbiter.sv
// Round-robin arbiter sharing one load path (one-hot load_en + shared d bus) into a register bank.
module reg_bank_load_arbiter
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int NREG  = 8,
    parameter int AW    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  err,
    output logic [NREG-1:0]       load_en,
    output logic [WIDTH-1:0]      d,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return 32'(a) < 32'(NREG);
    endfunction

    state_t            state_q, state_nxt;
    logic [PW-1:0]     ptr_q, ptr_nxt;
    logic [PW-1:0]     owner_q, owner_nxt;
    logic [AW-1:0]     addr_q, addr_nxt;
    logic [WIDTH-1:0]  data_q, data_nxt;
    logic [NREQ-1:0]   gnt_nxt, done_nxt;
    logic              err_nxt, busy_nxt;
    logic [NREG-1:0]   load_en_nxt;
    logic              pick_valid;
    logic [PW-1:0]     pick_idx;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Every output register is loaded one edge ahead, so the state's outputs appear in that state.
    always_comb begin
        state_nxt   = state_q;
        ptr_nxt     = ptr_q;
        owner_nxt   = owner_q;
        addr_nxt    = addr_q;
        data_nxt    = data_q;
        gnt_nxt     = '0;
        done_nxt    = '0;
        err_nxt     = 1'b0;
        load_en_nxt = '0;
        busy_nxt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ST_LOAD;
                    owner_nxt = pick_idx;
                    addr_nxt  = req_addr[pick_idx*AW +: AW];
                    data_nxt  = req_data[pick_idx*WIDTH +: WIDTH];
                    busy_nxt  = 1'b1;
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_nxt[i] = onehot_bit(32'(pick_idx), i);
                    end
                    for (int i = 0; i < NREG; i++) begin
                        load_en_nxt[i] = addr_ok(addr_nxt) & onehot_bit(32'(addr_nxt), i);
                    end
                end
            end
            ST_LOAD: begin
                state_nxt = ST_ACK;
                busy_nxt  = 1'b1;
                err_nxt   = !addr_ok(addr_q);
                for (int i = 0; i < NREQ; i++) begin
                    done_nxt[i] = onehot_bit(32'(owner_q), i);
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
                ptr_nxt   = (32'(owner_q) == 32'(NREQ - 1)) ? '0 : owner_q + PW'(1);
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            load_en <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ptr_q   <= ptr_nxt;
            owner_q <= owner_nxt;
            addr_q  <= addr_nxt;
            data_q  <= data_nxt;
            gnt     <= gnt_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            load_en <= load_en_nxt;
            busy    <= busy_nxt;
        end
    end

    // The latched data register drives the shared bus directly.
    assign d = data_q;

endmodule

// File: tb/tb_reg_bank_load_arbiter.sv
// Bench for reg_bank_load_arbiter: vector table, hand-written corner sequences, randomized model check.
module tb_reg_bank_load_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int NREG  = 8;
    localparam int AW    = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic [NREG-1:0]       load_en;
    logic [WIDTH-1:0]      d;
    logic                  busy;

    reg_bank_load_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .NREG  (NREG),
        .AW    (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .load_en  (load_en),
        .d        (d),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Register bank behind the arbiter; its own reset is independent, so it only starts at zero.
    logic [WIDTH-1:0] bank [NREG];
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (load_en[i]) bank[i] <= d;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic                  rst_n;
        logic [NREQ-1:0]       req;
        logic [NREQ*AW-1:0]    addr;
        logic [NREQ*WIDTH-1:0] data;
        logic [NREQ-1:0]       gnt;
        logic [NREQ-1:0]       done;
        logic                  err;
        logic [NREG-1:0]       le;
        logic [WIDTH-1:0]      d;
        logic                  busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*AW-1:0] a,
                       input logic [NREQ*WIDTH-1:0] dt, input logic [NREQ-1:0] eg,
                       input logic [NREQ-1:0] edn, input logic ee, input logic [NREG-1:0] el,
                       input logic [WIDTH-1:0] ed, input logic eb);
        vec_t v;
        v.rst_n = r;  v.req = rq;  v.addr = a;  v.data = dt;
        v.gnt = eg;   v.done = edn; v.err = ee; v.le = el; v.d = ed; v.busy = eb;
        tbl.push_back(v);
    endtask

    localparam logic [NREQ*AW-1:0]    A_RR  = {4'd3, 4'd2, 4'd1, 4'd0};
    localparam logic [NREQ*WIDTH-1:0] D_RR  = {16'h4243, 16'h4242, 16'h4241, 16'h4240};
    localparam logic [NREQ*AW-1:0]    A_ILL = {12'h000, 4'd9};
    localparam logic [NREQ*WIDTH-1:0] D_ILL = {48'h0, 16'hffff};
    localparam logic [NREQ*AW-1:0]    A_SW  = {4'd0, 4'd3, 4'd0, 4'd0};
    localparam logic [NREQ*WIDTH-1:0] D_SW  = {16'h0, 16'h00aa, 32'h0};
    localparam logic [NREQ*AW-1:0]    A_M   = {4'd0, 4'd0, 4'd5, 4'd0};
    localparam logic [NREQ*WIDTH-1:0] D_M   = {16'h0, 16'h0, 16'h4242, 16'h0};

    int k, last;
    int mptr, mphase, mown;
    logic [AW-1:0]    maddr;
    logic [WIDTH-1:0] mdata;
    logic [NREQ-1:0]  e_gnt, e_done, gexp;
    logic [NREG-1:0]  e_le;
    logic             e_err, e_busy;

    initial begin
        for (int i = 0; i < NREG; i++) bank[i] = '0;
        reset = 1'b0; req = '0; req_addr = '0; req_data = '0;

        //   rst req      addr   data   gnt      done     err  load_en         d          busy
        add(0, 4'b1111, A_RR,  D_RR,  4'b0000, 4'b0000, 0, 8'b0000_0000, 16'h0000, 0);
        add(0, 4'b1111, A_RR,  D_RR,  4'b0000, 4'b0000, 0, 8'b0000_0000, 16'h0000, 0);
        add(1, 4'b1111, A_RR,  D_RR,  4'b0001, 4'b0000, 0, 8'b0000_0001, 16'h4240, 1);
        add(1, 4'b1111, A_RR,  D_RR,  4'b0000, 4'b0001, 0, 8'b0000_0000, 16'h4240, 1);
        add(1, 4'b1111, A_RR,  D_RR,  4'b0000, 4'b0000, 0, 8'b0000_0000, 16'h4240, 0);
        add(1, 4'b1111, A_RR,  D_RR,  4'b0010, 4'b0000, 0, 8'b0000_0010, 16'h4241, 1);
        add(1, 4'b1111, A_RR,  D_RR,  4'b0000, 4'b0010, 0, 8'b0000_0000, 16'h4241, 1);
        add(1, 4'b1111, A_RR,  D_RR,  4'b0000, 4'b0000, 0, 8'b0000_0000, 16'h4241, 0);
        add(1, 4'b1111, A_RR,  D_RR,  4'b0100, 4'b0000, 0, 8'b0000_0100, 16'h4242, 1);
        add(1, 4'b1111, A_RR,  D_RR,  4'b0000, 4'b0100, 0, 8'b0000_0000, 16'h4242, 1);
        add(1, 4'b1111, A_RR,  D_RR,  4'b0000, 4'b0000, 0, 8'b0000_0000, 16'h4242, 0);
        add(1, 4'b1111, A_RR,  D_RR,  4'b1000, 4'b0000, 0, 8'b0000_1000, 16'h4243, 1);
        add(1, 4'b1111, A_RR,  D_RR,  4'b0000, 4'b1000, 0, 8'b0000_0000, 16'h4243, 1);
        // owner 3 just served; requesters 1 and 3 contend
        add(1, 4'b1010, A_RR,  D_RR,  4'b0000, 4'b0000, 0, 8'b0000_0000, 16'h4243, 0);
        add(1, 4'b1010, A_RR,  D_RR,  4'b0010, 4'b0000, 0, 8'b0000_0010, 16'h4241, 1);
        add(1, 4'b1010, A_RR,  D_RR,  4'b0000, 4'b0010, 0, 8'b0000_0000, 16'h4241, 1);
        add(1, 4'b1000, A_RR,  D_RR,  4'b0000, 4'b0000, 0, 8'b0000_0000, 16'h4241, 0);
        add(1, 4'b1000, A_RR,  D_RR,  4'b1000, 4'b0000, 0, 8'b0000_1000, 16'h4243, 1);
        add(1, 4'b1000, A_RR,  D_RR,  4'b0000, 4'b1000, 0, 8'b0000_0000, 16'h4243, 1);
        add(1, 4'b0000, A_RR,  D_RR,  4'b0000, 4'b0000, 0, 8'b0000_0000, 16'h4243, 0);
        // illegal address
        add(1, 4'b0001, A_ILL, D_ILL, 4'b0001, 4'b0000, 0, 8'b0000_0000, 16'hffff, 1);
        add(1, 4'b0001, A_ILL, D_ILL, 4'b0000, 4'b0001, 1, 8'b0000_0000, 16'hffff, 1);
        add(1, 4'b0000, A_ILL, D_ILL, 4'b0000, 4'b0000, 0, 8'b0000_0000, 16'hffff, 0);
        // single write from requester 2
        add(1, 4'b0100, A_SW,  D_SW,  4'b0100, 4'b0000, 0, 8'b0000_1000, 16'h00aa, 1);
        add(1, 4'b0100, A_SW,  D_SW,  4'b0000, 4'b0100, 0, 8'b0000_0000, 16'h00aa, 1);
        add(1, 4'b0000, A_SW,  D_SW,  4'b0000, 4'b0000, 0, 8'b0000_0000, 16'h00aa, 0);
        add(1, 4'b0000, A_SW,  D_SW,  4'b0000, 4'b0000, 0, 8'b0000_0000, 16'h00aa, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst_n; req = tbl[i].req;
            req_addr = tbl[i].addr; req_data = tbl[i].data;
            @(posedge clk); #1;
            check($sformatf("vec%0d.gnt", i),     64'(gnt),     64'(tbl[i].gnt));
            check($sformatf("vec%0d.done", i),    64'(done),    64'(tbl[i].done));
            check($sformatf("vec%0d.err", i),     64'(err),     64'(tbl[i].err));
            check($sformatf("vec%0d.load_en", i), 64'(load_en), 64'(tbl[i].le));
            check($sformatf("vec%0d.d", i),       64'(d),       64'(tbl[i].d));
            check($sformatf("vec%0d.busy", i),    64'(busy),    64'(tbl[i].busy));
        end
        check("bank3_single", 64'(bank[3]), 64'h00aa);
        for (int i = 4; i < NREG; i++) check($sformatf("bank%0d_untouched", i), 64'(bank[i]), 64'h0);

        // Reset asserted in the middle of a LOAD cycle (ptr is 3 here, so requester 1 wins).
        req = 4'b0010; req_addr = A_M; req_data = D_M;
        @(posedge clk); #1;
        check("midload.gnt", 64'(gnt), 64'b0010);
        check("midload.load_en", 64'(load_en), 64'b0010_0000);
        check("midload.d", 64'(d), 64'h4242);
        #2 reset = 1'b0;
        #1;
        check("midload_rst.gnt", 64'(gnt), 64'h0);
        check("midload_rst.load_en", 64'(load_en), 64'h0);
        check("midload_rst.busy", 64'(busy), 64'h0);
        check("midload_rst.d", 64'(d), 64'h0);
        req = '0;
        @(posedge clk); #1;
        check("midload_rst.done", 64'(done), 64'h0);
        check("midload_rst.bank5", 64'(bank[5]), 64'h0);
        @(negedge clk) reset = 1'b1;

        // All requesters held high: grants must rotate from 0 with a fixed 3-cycle spacing.
        req = '1; req_addr = A_RR; req_data = D_RR;
        k = 0; last = 0;
        for (int c = 0; c < 60 && k < 12; c++) begin
            @(posedge clk); #1;
            if (gnt != '0) begin
                gexp = '0; gexp[k % NREQ] = 1'b1;
                check($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(gexp));
                if (k > 0) check($sformatf("rr_gap%0d", k), 64'(c - last), 64'd3);
                last = c;
                k++;
            end
        end
        check("rr_count", 64'(k), 64'd12);
        req = '0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < NREG; i++)
            check($sformatf("rr_bank%0d", i), 64'(bank[i]), (i < NREQ) ? 64'(16'h4240 + i) : 64'h0);

        // Randomized traffic against a transaction-level reference model.
        @(negedge clk) reset = 1'b0;
        req = '0;
        @(negedge clk) reset = 1'b1;
        mptr = 0; mphase = 0; mown = 0; maddr = '0; mdata = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            e_gnt = '0; e_done = '0; e_err = 1'b0; e_le = '0; e_busy = 1'b0;
            if (mphase == 0) begin
                if (req != '0) begin
                    mown = -1;
                    for (int s = 0; s < NREQ; s++) begin
                        if (mown < 0 && req[(mptr + s) % NREQ]) mown = (mptr + s) % NREQ;
                    end
                    maddr = req_addr[mown*AW +: AW];
                    mdata = req_data[mown*WIDTH +: WIDTH];
                    e_gnt[mown] = 1'b1;
                    if (int'(maddr) < NREG) e_le[maddr] = 1'b1;
                    e_busy = 1'b1;
                    mphase = 1;
                end
            end else if (mphase == 1) begin
                e_done[mown] = 1'b1;
                e_err = (int'(maddr) >= NREG);
                e_busy = 1'b1;
                mphase = 2;
            end else begin
                mptr = (mown + 1) % NREQ;
                mphase = 0;
            end
            @(posedge clk); #1;
            check($sformatf("rnd%0d", cyc), 64'({gnt, done, err, load_en, d, busy}),
                  64'({e_gnt, e_done, e_err, e_le, mdata, e_busy}));
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && done[i]) begin
                    if ($urandom_range(3) != 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(2) == 0) begin
                        req[i] = 1'b1;
                        req_addr[i*AW +: AW] = AW'($urandom_range(9));
                        req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    end
                end else if ($urandom_range(7) == 0) begin
                    req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
